// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer around a one-bit full adder, LSB first
// Optional SERIAL_ADD_SUB_EN adds a sub input (a-b) and a signed-overflow output ovf.

module bAdd (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             bit_sum, bit_cout;
  logic             last_bit;
  logic             load_carry;
  logic [WIDTH-1:0] load_b;

  bAdd u_badd (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry),
    .sum   (bit_sum),
    .c_out (bit_cout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1; the caller's c_in is irrelevant then.
  assign load_b     = sub ? ~b : b;
  assign load_carry = sub ? 1'b1 : c_in;
`else
  assign load_b     = b;
  assign load_carry = c_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      done  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_sh  <= a;
          b_sh  <= load_b;
          carry <= load_carry;
          cnt   <= '0;
        end
      end else begin
        // sum doubles as the result shift register, filled from the MSB end
        sum   <= {bit_sum, sum[WIDTH-1:1]};
        carry <= bit_cout;
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        cnt   <= cnt + 1'b1;
        if (last_bit) begin
          c_out <= bit_cout;
          done  <= 1'b1;
`ifdef SERIAL_ADD_SUB_EN
          ovf   <= carry ^ bit_cout;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl with arithmetic reference model
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, busy, done, c_out;
  logic [W-1:0] sum;
`ifdef SERIAL_ADD_SUB_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int checks = 0, fails = 0, cyc = 0, issued = 0, dones = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
    .ovf   (ovf),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: got no end of test, required finish within 2ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic ic, input logic is);
    exp_t e;
    int ua, ub, sa, sbv, r, sr;
    ua  = int'(ia);
    ub  = int'(ib);
    sa  = ia[W-1] ? ua - (1 << W) : ua;
    sbv = ib[W-1] ? ub - (1 << W) : ub;
    if (is) begin
      r   = ua - ub + (1 << W);
      e.c = (ua >= ub);
      sr  = sa - sbv;
    end else begin
      r   = ua + ub + int'(ic);
      e.c = (r >= (1 << W));
      sr  = sa + sbv + int'(ic);
    end
    e.s   = r[W-1:0];
    e.v   = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    e.acc = 0;
    return e;
  endfunction

  task automatic push(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic, input logic is);
    exp_t e;
    e = model(ia, ib, ic, is);
    e.acc = cyc;
    sb.push_back(e);
    issued++;
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input logic is, input bit ready_chk);
    int t = 0;
    while (ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", ready, 1);
    a = ia; b = ib; c_in = ic; sub = is; start = 1'b1;
    @(posedge clk); #1;
    push(ia, ib, ic, is);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    if (ready_chk)
      for (int i = 0; i < W; i++) begin
        @(negedge clk);
        chk("ready_low", ready, 0);
        chk("busy_high", busy, 1);
      end
    @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      dones++;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1 required no pending op (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", sum, e.s);
        chk("c_out", c_out, e.c);
        chk("latency", cyc - e.acc, W);
`ifdef SERIAL_ADD_SUB_EN
        chk("ovf", ovf, e.v);
`endif
      end
    end
  end

  initial begin
    logic is;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_c_out", c_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'h3C, 8'h45, 1'b0, 1'b0, 1'b1);
    issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    issue(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
    drain();

    // start held through the op; operand change mid-run must be ignored
    a = 8'h10; b = 8'h20; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    push(8'h10, 8'h20, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    a = 8'hAA;
    repeat (W - 2) @(posedge clk);
    #1;
    push(8'hAA, 8'h20, 1'b0, 1'b0);
    start = 1'b0;
    @(negedge clk);
    drain();

    // reset in the middle of an operation
    a = 8'h7F; b = 8'h01; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_sum", sum, 0);
    chk("abort_c_out", c_out, 0);
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);
    issue(8'h02, 8'h03, 1'b0, 1'b0, 1'b0);
    drain();

`ifdef SERIAL_ADD_SUB_EN
    issue(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
    issue(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
    drain();
`endif

    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
`ifdef SERIAL_ADD_SUB_EN
      is = 1'($urandom);
`else
      is = 1'b0;
`endif
      issue(W'($urandom), W'($urandom), 1'($urandom), is, 1'b0);
    end
    drain();
    repeat (W + 2) @(negedge clk);
    chk("done_count", dones, issued);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
